// File: rtl/branch_dir_predictor.sv
// ---------------------------------------------------------------------------
// branch_dir_predictor
//   Gshare direction predictor with fetch next-PC select. Sits beside the BTB
//   in IF: looks up a 2-bit counter table (PHT) indexed by fetch PC XOR global
//   history, and picks the BTB target or PC+4. Trained from EX at branch
//   resolution, which also repairs the speculative global history on a
//   mispredict. Keeps saturating branch / mispredict counters for perf stats.
//
// Ports
//   CLK, nRST                    clock, asynchronous active-low reset
//   fetch_pc, fetch_valid        current fetch PC, IF advancing this cycle
//   btb_hit, btb_target          BTB lookup result for fetch_pc
//   npc_pred, pred_taken         predicted next PC and direction
//   pred_index, pred_ghr         PHT index / history used, carried to EX
//   upd_valid, upd_index,        resolution of a conditional branch in EX,
//   upd_ghr, upd_taken,          with the index/history it was predicted with
//   upd_mispredict
//   branch_cnt, mispred_cnt      saturating performance counters
//
// CNT_RST is the value the performance counters take on reset (normally 0).
// ---------------------------------------------------------------------------
module branch_dir_predictor #(
  parameter int          IDX_W   = 11,
  parameter int          GHR_W   = 8,
  parameter logic [31:0] CNT_RST = 32'h0000_0000
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_valid,
  input  logic             btb_hit,
  input  logic [31:0]      btb_target,
  output logic [31:0]      npc_pred,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_index,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int PHT_ENTRIES = 2 ** IDX_W;

  // Every entry must return to weakly-not-taken on an asynchronous reset,
  // so the table is held in flops rather than a RAM.
  logic [1:0]       pht_reg [PHT_ENTRIES];
  logic [1:0]       pht_old;
  logic [1:0]       pht_next;
  logic [GHR_W-1:0] ghr_reg;
  logic [GHR_W-1:0] ghr_next;
  logic [31:0]      branch_cnt_reg;
  logic [31:0]      branch_cnt_next;
  logic [31:0]      mispred_cnt_reg;
  logic [31:0]      mispred_cnt_next;

  // The oldest bit of the carried history falls off the end of the repair shift.
  logic unused_upd_ghr_msb;
  assign unused_upd_ghr_msb = upd_ghr[GHR_W-1];

  // ---------------- lookup (combinational) ----------------
  // History is zero-extended into the low index bits.
  assign pred_index = fetch_pc[IDX_W+1:2] ^ IDX_W'(ghr_reg);
  assign pred_ghr   = ghr_reg;
  // Reads the registered table directly: a same-cycle update is not bypassed.
  assign pred_taken = pht_reg[pred_index][1] & btb_hit;
  assign npc_pred   = pred_taken ? btb_target : (fetch_pc + 32'd4);

  // ---------------- PHT training ----------------
  always_comb begin
    pht_old  = pht_reg[upd_index];
    pht_next = pht_old;
    if (upd_taken) begin
      if (pht_old != 2'b11) pht_next = pht_old + 2'd1;
    end else begin
      if (pht_old != 2'b00) pht_next = pht_old - 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht_reg[i] <= 2'b01;
    end else if (upd_valid) begin
      pht_reg[upd_index] <= pht_next;
    end
  end

  // ---------------- global history ----------------
  // A mispredict repair rebuilds history from the branch's own snapshot plus
  // its real outcome; anything speculated after it is wrong, so the repair
  // wins over a same-cycle speculative shift.
  always_comb begin
    ghr_next = ghr_reg;
    if (upd_valid && upd_mispredict) begin
      ghr_next = {upd_ghr[GHR_W-2:0], upd_taken};
    end else if (fetch_valid && btb_hit) begin
      ghr_next = {ghr_reg[GHR_W-2:0], pred_taken};
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) ghr_reg <= '0;
    else       ghr_reg <= ghr_next;
  end

  // ---------------- performance counters (saturating) ----------------
  always_comb begin
    branch_cnt_next  = branch_cnt_reg;
    mispred_cnt_next = mispred_cnt_reg;
    if (upd_valid) begin
      if (branch_cnt_reg != 32'hFFFF_FFFF)
        branch_cnt_next = branch_cnt_reg + 32'd1;
      if (upd_mispredict && (mispred_cnt_reg != 32'hFFFF_FFFF))
        mispred_cnt_next = mispred_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_cnt_reg  <= CNT_RST;
      mispred_cnt_reg <= CNT_RST;
    end else begin
      branch_cnt_reg  <= branch_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  assign branch_cnt  = branch_cnt_reg;
  assign mispred_cnt = mispred_cnt_reg;

endmodule
